serializer_8: RTL
=================

SERIALIZER_8 -- requirements
Module: serializer_8

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per frame (WIDTH >= 2).
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; forces IDLE and all outputs to reset values immediately.
REQ-004 Start  input  1  request to transmit Din; sampled on the rising edge of Clock.
REQ-005 Din  input  WIDTH  parallel word; captured on the edge that accepts Start.
REQ-006 MsbFirst  input  1  bit order; 1 = MSB first, 0 = LSB first; captured with Din.
REQ-007 SerOut  output  1  serial data bit; 0 when not Busy.
REQ-008 Busy  output  1  high while a frame is being shifted out.
REQ-009 Done  output  1  single-cycle pulse after the last bit of a frame.
REQ-010 BitCount  output  clog2(WIDTH)  index of the bit currently on SerOut (0 = first bit); 0 when not Busy.

Function
REQ-011 States SHALL be IDLE, SHIFT, DONE; the encoding is internal and registered.
REQ-012 IDLE: Busy=0, Done=0, SerOut=0, BitCount=0; Start=1 at an edge -> load Din and MsbFirst, BitCount<=0, go to SHIFT.
REQ-013 Latency: the first bit is on SerOut in the cycle immediately after the accepting edge; there is no bubble cycle.
REQ-014 SHIFT: SerOut = shift-register MSB if the captured MsbFirst=1, else LSB; each edge shifts by one toward the output end and increments BitCount.
REQ-015 Bit i of the frame (i = 0..WIDTH-1) SHALL be held on SerOut for exactly one clock cycle; a frame lasts exactly WIDTH cycles.
REQ-016 The edge after the cycle in which BitCount = WIDTH-1 is visible -> go to DONE; BitCount SHALL NOT wrap past WIDTH-1 while in SHIFT.
REQ-017 DONE: Done=1, Busy=0, SerOut=0 for exactly one cycle; the next edge goes to IDLE, or to SHIFT with a new load if Start=1 (back-to-back frames, one-cycle gap).
REQ-018 Start during SHIFT SHALL be ignored: no reload, no queuing, and the current frame is unaffected.
REQ-019 Din and MsbFirst changes after the accepting edge SHALL NOT affect the frame in progress.
REQ-020 Start held high continuously SHALL produce frames separated by one DONE cycle each.
REQ-021 Shift-register fill bits shifted in SHALL be 0; they never appear on SerOut within a frame.
REQ-022 All outputs SHALL be driven from registered state or a mux of registered state only; there is no combinational path from any input to any output.

Reset
REQ-023 Reset=0 SHALL asynchronously force state=IDLE, the shift register to all 0, BitCount=0, SerOut=0, Busy=0, Done=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no Done pulse; the partial frame is discarded.
REQ-025 While Reset=0, Start SHALL be ignored; the first edge with Reset=1 and Start=1 is accepted normally.
REQ-026 Reset has priority over every synchronous event, including a simultaneous Start.

Verification
REQ-027 MSB-first frame: Din=8'hA5, MsbFirst=1, Start pulsed one cycle -> SerOut = 1,0,1,0,0,1,0,1 over cycles 1-8, Busy=1 in those cycles, Done=1 in cycle 9, then IDLE.
REQ-028 LSB-first frame: Din=8'hA5, MsbFirst=0 -> SerOut = 1,0,1,0,0,1,0,1 (palindrome check); then Din=8'h01 -> SerOut = 1,0,0,0,0,0,0,0, BitCount 0..7.
REQ-029 Ignored Start: Start re-pulsed with Din=8'hFF during bit 3 of a frame of 8'h00 -> SerOut stays all 0, a single Done, no second frame.
REQ-030 Back-to-back: Start held high, Din=8'hF0 then 8'h0F -> frame 1, one DONE cycle (SerOut=0), then frame 2 immediately; 17 cycles total.
REQ-031 Reset mid-frame: Reset driven low asynchronously (between edges) during bit 4 -> Busy, SerOut, BitCount go to 0 at once, no Done; after release, a new Start of 8'h81 transmits correctly.

Source files
------------

// File: rtl/serializer_8_if.sv
// Parallel-load / serial-out bus between a frame producer and serializer_8.
// Start is the request; the serializer takes it on any edge where it is not shifting (Busy=0).
interface serializer_8_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             Start;
    logic [WIDTH-1:0] Din;
    logic             MsbFirst;
    logic             SerOut;
    logic             Busy;
    logic             Done;
    logic [CW-1:0]    BitCount;

    modport master (
        output Start, Din, MsbFirst,
        input  SerOut, Busy, Done, BitCount
    );

    modport slave (
        input  Start, Din, MsbFirst,
        output SerOut, Busy, Done, BitCount
    );
endinterface

// File: rtl/serializer_8.sv
// Frame serializer: loads WIDTH bits on an accepted Start and shifts them out one per cycle,
// followed by a single-cycle Done. Outputs come only from registered state.
module serializer_8 #(
    parameter int WIDTH = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    serializer_8_if.slave  bus,
    output logic [1:0]     DbgState
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             msb_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            shreg  <= '0;
            msb_q  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state  <= SHIFT;
                        shreg  <= bus.Din;
                        msb_q  <= bus.MsbFirst;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Start is deliberately not looked at here: no reload, no queuing.
                    if (cnt == LAST) begin
                        state  <= DONE;
                        shreg  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        shreg <= msb_q ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        state  <= SHIFT;
                        shreg  <= bus.Din;
                        msb_q  <= bus.MsbFirst;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // The output end of the shift register depends on the captured bit order.
    assign bus.SerOut   = busy_q & (msb_q ? shreg[WIDTH-1] : shreg[0]);
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.BitCount = cnt;
    assign DbgState     = state;
endmodule
